tag_filter: RTL and testbench

TAG_FILTER -- requirements
Module: tag_filter

---
 rtl/tag_filter_pkg.sv | 16 +
 rtl/tag_filter_bit.sv | 71 +++++++
 rtl/tag_filter.sv | 33 +++
 tb/tb_tag_filter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tag_filter_pkg.sv
// Shared types for the tag filter: per-bit edge event classification.
package tag_filter_pkg;

  // Outcome of one filter decision on a single line.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RISE = 2'd1,
    EV_FALL = 2'd2
  } edge_ev_e;

  // Direction of an accepted change, given the level being adopted.
  function automatic edge_ev_e classify_edge(input logic new_level);
    return new_level ? EV_RISE : EV_FALL;
  endfunction

endpackage : tag_filter_pkg

// File: rtl/tag_filter_bit.sv
// One line of the tag filter: two-flop synchronizer followed by an
// N-sample stability qualifier producing a clean level and edge pulses.
module tag_filter_bit
  import tag_filter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = $clog2(N + 1);

  // A zero-length stability window is meaningless; refuse to elaborate.
  if (N < 1) begin : g_n_check
    $error("tag_filter_bit: N must be >= 1");
  end

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          rise_q;
  logic          fall_q;
  edge_ev_e      ev_d;

  // Stability qualifier: count consecutive mismatching samples, accept on the Nth.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    ev_d    = EV_NONE;
    if (s2_q != level_q) begin
      if (cnt_q == CW'(N - 1)) begin
        level_d = s2_q;
        ev_d    = classify_edge(s2_q);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter, level and pulse registers; reset discards any count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= i_in;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= (ev_d == EV_RISE);
      fall_q  <= (ev_d == EV_FALL);
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule : tag_filter_bit

// File: rtl/tag_filter.sv
// W independent filtered tag lines with per-bit edge pulses and a global
// change flag; outputs group cleanly by width W for downstream delay lines.
module tag_filter #(
  parameter int unsigned W = 1,
  parameter int          N = 3
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall,
  output logic         o_change
);

  // One identical filter per line; lines never interact.
  for (genvar g = 0; g < W; g++) begin : g_bit
    tag_filter_bit #(
      .N(N)
    ) u_bit (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_in      (i_in[g]),
      .o_level   (o_level[g]),
      .o_rise    (o_rise[g]),
      .o_fall    (o_fall[g])
    );
  end

  // Any accepted edge on any line, straight from the registered pulses.
  assign o_change = |{o_rise, o_fall};

endmodule : tag_filter

// File: tb/tb_tag_filter.sv
// Randomized bench for tag_filter at N=3, N=2 and N=1 (W=4 each) against a
// window-based reference: a line flips when its last N synchronized samples
// all disagree with the current filtered level.
module tb_tag_filter;

  localparam int unsigned W  = 4;
  localparam int unsigned NI = 3;
  localparam int unsigned HD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_v  [NI];
  logic [W-1:0] drv   [NI];
  logic [W-1:0] lvl   [NI];
  logic [W-1:0] rise  [NI];
  logic [W-1:0] fall  [NI];
  logic         chg   [NI];

  logic [W-1:0] m_p0  [NI];
  logic [W-1:0] m_p1  [NI];
  logic [W-1:0] m_h   [NI][HD];
  logic [W-1:0] m_lvl [NI];
  logic [W-1:0] m_rise[NI];
  logic [W-1:0] m_fall[NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tag_filter #(.W(W), .N(3)) u_n3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_in(in_v[0]),
    .o_level(lvl[0]), .o_rise(rise[0]), .o_fall(fall[0]), .o_change(chg[0]));

  tag_filter #(.W(W), .N(2)) u_n2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_in(in_v[1]),
    .o_level(lvl[1]), .o_rise(rise[1]), .o_fall(fall[1]), .o_change(chg[1]));

  tag_filter #(.W(W), .N(1)) u_n1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_in(in_v[2]),
    .o_level(lvl[2]), .o_rise(rise[2]), .o_fall(fall[2]), .o_change(chg[2]));

  function automatic int n_of(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 2 : 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_p0[i]   = '0;
      m_p1[i]   = '0;
      m_lvl[i]  = '0;
      m_rise[i] = '0;
      m_fall[i] = '0;
      for (int j = 0; j < HD; j++) m_h[i][j] = '0;
    end
  endtask

  // Reference for one rising clock edge, using the inputs presented at it.
  task automatic model_edge();
    logic [W-1:0] s2v;
    bit           acc;
    for (int i = 0; i < NI; i++) begin
      s2v     = m_p1[i];
      m_p1[i] = m_p0[i];
      m_p0[i] = in_v[i];
      for (int j = HD - 1; j > 0; j--) m_h[i][j] = m_h[i][j-1];
      m_h[i][0] = s2v;
      m_rise[i] = '0;
      m_fall[i] = '0;
      for (int b = 0; b < W; b++) begin
        acc = 1'b1;
        for (int j = 0; j < n_of(i); j++)
          if (m_h[i][j][b] == m_lvl[i][b]) acc = 1'b0;
        if (acc) begin
          if (m_lvl[i][b]) m_fall[i][b] = 1'b1;
          else             m_rise[i][b] = 1'b1;
          m_lvl[i][b] = ~m_lvl[i][b];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("level%0d", i),  32'(lvl[i]),  32'(m_lvl[i]));
      check_eq($sformatf("rise%0d", i),   32'(rise[i]), 32'(m_rise[i]));
      check_eq($sformatf("fall%0d", i),   32'(fall[i]), 32'(m_fall[i]));
      check_eq($sformatf("change%0d", i), 32'(chg[i]),  32'(|(m_rise[i] | m_fall[i])));
    end
  endtask

  // Present drv, take one clock edge, then compare everything just after it.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) in_v[i] = drv[i];
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < NI; i++) drv[i] = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s_level%0d", tag, i), 32'(lvl[i]), 32'd0);
      check_eq($sformatf("%s_pulse%0d", tag, i), 32'(rise[i] | fall[i]), 32'd0);
      check_eq($sformatf("%s_change%0d", tag, i), 32'(chg[i]), 32'd0);
    end
  endtask

  initial begin
    logic seen_r;
    logic seen_f;
    int   first_r;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_v[i] = '0;
      drv[i]  = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Clean step on bit 0: N=3 accepts at edge 5, N=2 at edge 4, N=1 at edge 3.
    set_all(4'b0001);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 2) check_eq("n1_e2_level", 32'(lvl[2][0]), 32'd0);
      if (k == 3) check_eq("n1_e3_rise", 32'(rise[2][0]), 32'd1);
      if (k == 3) check_eq("n2_e3_level", 32'(lvl[1][0]), 32'd0);
      if (k == 4) check_eq("n2_e4_rise", 32'(rise[1][0]), 32'd1);
      if (k == 4) check_eq("n3_e4_level", 32'(lvl[0][0]), 32'd0);
      if (k == 5) check_eq("n3_e5_level", 32'(lvl[0][0]), 32'd1);
      if (k == 5) check_eq("n3_e5_rise", 32'(rise[0][0]), 32'd1);
      if (k == 5) check_eq("n3_e5_change", 32'(chg[0]), 32'd1);
      if (k == 6) check_eq("n3_e6_rise", 32'(rise[0][0]), 32'd0);
      if (k == 6) check_eq("n3_e6_change", 32'(chg[0]), 32'd0);
    end

    // Multi-bit simultaneous acceptance on N=2: 0000 -> 1010 rises together.
    set_all(4'b0000);
    repeat (8) step();
    set_all(4'b1010);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) check_eq("n2_multi_rise", 32'(rise[1]), 32'hA);
      if (k == 4) check_eq("n2_multi_fall", 32'(fall[1]), 32'h0);
      if (k == 4) check_eq("n2_multi_change", 32'(chg[1]), 32'd1);
    end

    // Glitches on N=3: two samples rejected, three accepted then undone.
    set_all(4'b0000);
    repeat (8) step();
    seen_r = 1'b0;
    set_all(4'b0001); repeat (2) step();
    seen_r |= rise[0][0];
    set_all(4'b0000);
    for (int k = 0; k < 6; k++) begin step(); seen_r |= rise[0][0]; end
    check_eq("n3_glitch2_rise", 32'(seen_r), 32'd0);
    seen_r = 1'b0;
    seen_f = 1'b0;
    set_all(4'b0001);
    for (int k = 0; k < 3; k++) begin step(); seen_r |= rise[0][0]; end
    set_all(4'b0000);
    for (int k = 0; k < 8; k++) begin
      step();
      seen_r |= rise[0][0];
      seen_f |= fall[0][0];
    end
    check_eq("n3_glitch3_rise", 32'(seen_r), 32'd1);
    check_eq("n3_glitch3_fall", 32'(seen_f), 32'd1);

    // Interrupted deviation on N=3: high, high, low, then high held.
    first_r = 0;
    for (int k = 1; k <= 12; k++) begin
      set_all((k == 3) ? 4'b0000 : 4'b0001);
      step();
      if (rise[0][0] && first_r == 0) first_r = k;
    end
    check_eq("n3_restart_edge", 32'(first_r), 32'd8);

    // Reset mid-count: inputs high, reset between edges clears everything at once.
    set_all(4'b0000);
    repeat (8) step();
    set_all(4'b1111);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) check_eq("rst_n3_e4_level", 32'(lvl[0]), 32'h0);
      if (k == 5) check_eq("rst_n3_e5_rise", 32'(rise[0]), 32'hF);
    end

    // Random traffic: sparse then dense flips per line.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NI; i++)
        for (int b = 0; b < W; b++)
          if ($urandom_range(0, (k < 300) ? 4 : 1) == 0) drv[i][b] = ~drv[i][b];
      step();
      if (k == 450) begin
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("rand_rst");
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_tag_filter
